// File: rtl/mpmc11_rd_strip_collect.sv
// Read-burst receive side: counts returning read beats against the requested strip count and
// forwards each beat, registered, to the read cache with its 32-byte-aligned strip address.
module mpmc11_rd_strip_collect #(
    parameter int unsigned WID       = 256,
    parameter int unsigned PORT_BITS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [5:0]           i_num_strips,
    input  logic [31:0]          i_addr_base,
    input  logic [PORT_BITS-1:0] i_port,
    input  logic                 i_rd_valid,
    input  logic [WID-1:0]       i_rd_data,
    output logic [5:0]           o_strip_cnt,
    output logic                 o_busy,
    output logic                 o_rc_we,
    output logic [31:0]          o_rc_adr,
    output logic [WID-1:0]       o_rc_dat,
    output logic [PORT_BITS-1:0] o_rc_port,
    output logic                 o_done,
    output logic                 o_err_orphan
);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e               r_state, w_state;
    logic [5:0]           r_n, w_n;
    logic [31:0]          r_base, w_base;
    logic [PORT_BITS-1:0] r_port, w_port;
    logic [5:0]           r_cnt, w_cnt;
    logic                 r_rc_we, w_rc_we;
    logic [31:0]          r_rc_adr, w_rc_adr;
    logic [WID-1:0]       r_rc_dat, w_rc_dat;
    logic [PORT_BITS-1:0] r_rc_port, w_rc_port;
    logic                 r_done, w_done;
    logic                 r_err, w_err;

    always_comb begin
        w_state   = r_state;
        w_n       = r_n;
        w_base    = r_base;
        w_port    = r_port;
        w_cnt     = r_cnt;
        w_rc_we   = 1'b0;
        w_rc_adr  = r_rc_adr;
        w_rc_dat  = r_rc_dat;
        w_rc_port = r_rc_port;
        w_done    = 1'b0;
        w_err     = r_err;
        unique case (r_state)
            StIdle: begin
                // A beat seen here belongs to no burst, even if start arrives alongside it.
                if (i_rd_valid) begin
                    w_err = 1'b1;
                end
                if (i_start) begin
                    w_state = StCollect;
                    w_n     = i_num_strips;
                    w_base  = {i_addr_base[31:5], 5'h0};
                    w_port  = i_port;
                    w_cnt   = 6'd0;
                end
            end
            StCollect: begin
                if (i_rd_valid) begin
                    w_rc_we   = 1'b1;
                    w_rc_adr  = r_base + {21'h0, r_cnt, 5'h0};
                    w_rc_dat  = i_rd_data;
                    w_rc_port = r_port;
                    w_cnt     = r_cnt + 6'd1;
                    if (r_cnt == r_n) begin
                        w_done  = 1'b1;
                        w_state = StIdle;
                    end
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_n       <= '0;
            r_base    <= '0;
            r_port    <= '0;
            r_cnt     <= '0;
            r_rc_we   <= 1'b0;
            r_rc_adr  <= '0;
            r_rc_dat  <= '0;
            r_rc_port <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_n       <= w_n;
            r_base    <= w_base;
            r_port    <= w_port;
            r_cnt     <= w_cnt;
            r_rc_we   <= w_rc_we;
            r_rc_adr  <= w_rc_adr;
            r_rc_dat  <= w_rc_dat;
            r_rc_port <= w_rc_port;
            r_done    <= w_done;
            r_err     <= w_err;
        end
    end

    assign o_strip_cnt  = r_cnt;
    assign o_busy       = (r_state == StCollect);
    assign o_rc_we      = r_rc_we;
    assign o_rc_adr     = r_rc_adr;
    assign o_rc_dat     = r_rc_dat;
    assign o_rc_port    = r_rc_port;
    assign o_done       = r_done;
    assign o_err_orphan = r_err;

endmodule

// File: tb/tb_mpmc11_rd_strip_collect.sv
// Bench for mpmc11_rd_strip_collect: directed test-plan bursts plus random traffic, every cycle
// compared against a burst-level reference model.
module tb_mpmc11_rd_strip_collect;

    localparam int unsigned WID       = 256;
    localparam int unsigned PORT_BITS = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [5:0]           num_strips = '0;
    logic [31:0]          addr_base = '0;
    logic [PORT_BITS-1:0] port = '0;
    logic                 rd_valid = 1'b0;
    logic [WID-1:0]       rd_data = '0;
    logic [5:0]           strip_cnt;
    logic                 busy, rc_we, done, err_orphan;
    logic [31:0]          rc_adr;
    logic [WID-1:0]       rc_dat;
    logic [PORT_BITS-1:0] rc_port;

    always #5 clk = ~clk;

    mpmc11_rd_strip_collect #(.WID(WID), .PORT_BITS(PORT_BITS)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_strips (num_strips),
        .i_addr_base  (addr_base),
        .i_port       (port),
        .i_rd_valid   (rd_valid),
        .i_rd_data    (rd_data),
        .o_strip_cnt  (strip_cnt),
        .o_busy       (busy),
        .o_rc_we      (rc_we),
        .o_rc_adr     (rc_adr),
        .o_rc_dat     (rc_dat),
        .o_rc_port    (rc_port),
        .o_done       (done),
        .o_err_orphan (err_orphan)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Reference model: burst bookkeeping plus the values the cache port should show.
    bit                   m_coll;
    int                   m_n, m_cnt;
    logic [31:0]          m_base;
    logic [PORT_BITS-1:0] m_port;
    logic                 e_we, e_done, e_err;
    logic [31:0]          e_adr;
    logic [WID-1:0]       e_dat;
    logic [PORT_BITS-1:0] e_port;

    logic [31:0] adr_log[$];
    int          done_cnt;

    task automatic model_edge();
        if (rst) begin
            m_coll = 0; m_n = 0; m_cnt = 0; m_base = '0; m_port = '0;
            e_we = 0; e_done = 0; e_err = 0; e_adr = '0; e_dat = '0; e_port = '0;
            return;
        end
        e_we   = 0;
        e_done = 0;
        if (m_coll) begin
            if (rd_valid) begin
                e_we   = 1;
                e_adr  = m_base + 32'(m_cnt * 32);
                e_dat  = rd_data;
                e_port = m_port;
                if (m_cnt == m_n) begin
                    e_done = 1;
                    m_coll = 0;
                end
                m_cnt = (m_cnt + 1) % 64;
            end
        end else begin
            if (rd_valid) e_err = 1;
            if (start) begin
                m_coll = 1;
                m_n    = int'(num_strips);
                m_base = addr_base & 32'hFFFF_FFE0;
                m_port = port;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit v);
        logic [WID-1:0] d;
        for (int k = 0; k < WID / 32; k++) d[k*32 +: 32] = $urandom;
        rst = r; start = s; rd_valid = v; rd_data = d;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("rc_we", WID'(rc_we), WID'(e_we));
        check_eq("done", WID'(done), WID'(e_done));
        check_eq("busy", WID'(busy), WID'(m_coll));
        check_eq("strip_cnt", WID'(strip_cnt), WID'(m_cnt));
        check_eq("err_orphan", WID'(err_orphan), WID'(e_err));
        check_eq("rc_adr", WID'(rc_adr), WID'(e_adr));
        check_eq("rc_dat", rc_dat, e_dat);
        check_eq("rc_port", WID'(rc_port), WID'(e_port));
        if (rc_we) adr_log.push_back(rc_adr);
        if (done) done_cnt++;
    endtask

    task automatic set_burst(input logic [5:0] ns, input logic [31:0] ab, input logic [3:0] pt);
        num_strips = ns; addr_base = ab; port = pt;
    endtask

    task automatic clear_log();
        adr_log.delete();
        done_cnt = 0;
    endtask

    task automatic check_log(input string tag, input int exp_n, input logic [31:0] a0,
                             input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] exp_a[4];
        exp_a = '{a0, a1, a2, a3};
        check_eq({tag, "_nwr"}, WID'(adr_log.size()), WID'(exp_n));
        for (int i = 0; i < exp_n && i < adr_log.size() && i < 4; i++)
            check_eq($sformatf("%s_adr%0d", tag, i), WID'(adr_log[i]), WID'(exp_a[i]));
    endtask

    initial begin
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        check_eq("reset_busy", WID'(busy), '0);
        check_eq("reset_cnt", WID'(strip_cnt), '0);

        // Basic burst.
        clear_log();
        set_burst(6'd3, 32'h0000_1234, 4'd5);
        cyc(0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        check_eq("basic_rcport", WID'(rc_port), WID'(5));
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_log("basic", 4, 32'h1220, 32'h1240, 32'h1260, 32'h1280);
        check_eq("basic_done", WID'(done_cnt), WID'(1));
        check_eq("basic_cnt", WID'(strip_cnt), WID'(4));

        // Gapped beats.
        clear_log();
        cyc(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
            cyc(0, 0, 0);
        end
        check_log("gap", 4, 32'h1220, 32'h1240, 32'h1260, 32'h1280);
        check_eq("gap_done", WID'(done_cnt), WID'(1));

        // Single strip.
        clear_log();
        set_burst(6'd0, 32'hFFFF_FFE7, 4'd2);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        check_eq("single_done_with_we", WID'(done & rc_we), WID'(1));
        cyc(0, 0, 0);
        check_log("single", 1, 32'hFFFF_FFE0, 0, 0, 0);

        // Address wrap.
        clear_log();
        set_burst(6'd2, 32'hFFFF_FFC0, 4'd9);
        cyc(0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        check_log("wrap", 3, 32'hFFFF_FFC0, 32'hFFFF_FFE0, 32'h0000_0000, 0);

        // Orphan beat in IDLE.
        clear_log();
        check_eq("orphan_pre", WID'(err_orphan), '0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check_eq("orphan_err", WID'(err_orphan), WID'(1));
        check_eq("orphan_nwr", WID'(adr_log.size()), '0);

        // Start mid-burst is ignored.
        clear_log();
        set_burst(6'd1, 32'h0000_4000, 4'd3);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        set_burst(6'd7, 32'h0000_8000, 4'd7);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0);
        check_log("ignore", 2, 32'h4000, 32'h4020, 0, 0);
        check_eq("ignore_done", WID'(done_cnt), WID'(1));

        // Reset mid-burst.
        clear_log();
        set_burst(6'd3, 32'h0000_2000, 4'd1);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        check_eq("rst_mid_busy", WID'(busy), '0);
        check_eq("rst_mid_adr", WID'(rc_adr), '0);
        cyc(0, 0, 1);
        check_eq("rst_mid_orphan", WID'(err_orphan), WID'(1));
        check_eq("rst_mid_nodone", WID'(done_cnt), '0);
        clear_log();
        cyc(0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1);
        check_log("rst_fresh", 4, 32'h2000, 32'h2020, 32'h2040, 32'h2060);
        check_eq("rst_fresh_done", WID'(done_cnt), WID'(1));

        // Random traffic, including 64-beat bursts that wrap strip_cnt.
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 16) == 0)
                set_burst(($urandom % 4 == 0) ? 6'd63 : 6'($urandom_range(0, 7)),
                          $urandom, 4'($urandom));
            cyc(($urandom % 400) == 0, ($urandom % 6) == 0, ($urandom % 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
